sram_arbiter_2p: RTL

Two-port arbiter and sequencer for the shared external 16-bit SRAM (IS61WV25616). Port 0 is a read-only instruction-fetch requester; port 1 is the LSU data requester, with reads and byte-masked writes. Each granted 32-bit access becomes two 16-bit SRAM phases, low half first. The block drives all SRAM pins and sits between the pipeline front-end/LSU and the board SRAM.

---
 rtl/sram_arbiter_2p.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter_2p.sv
// Two-port arbiter/sequencer for a 16-bit async SRAM; each 32-bit access runs as a LO then a HI half-phase.
// Latency: 2*WAIT_CYC+1 for reads and full writes, WAIT_CYC+1 for a one-half write, 1 for an empty byte mask.
// Backpressure: requests are level-held until ack; the losing port waits for the next IDLE. Macro ARB_ROUND_ROBIN_EN selects round-robin ties.
module sram_arbiter_2p #(
  parameter int WAIT_CYC = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_p0_req,
  input  logic [31:0] i_p0_addr,
  output logic [31:0] o_p0_rdata,
  output logic        o_p0_ack,
  input  logic        i_p1_req,
  input  logic        i_p1_wren,
  input  logic [31:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  input  logic [3:0]  i_p1_bmask,
  output logic [31:0] o_p1_rdata,
  output logic        o_p1_ack,
  output logic        o_busy,
  output logic [17:0] o_SRAM_ADDR,
  inout  wire  [15:0] o_SRAM_DQ,
  output logic        o_SRAM_CE_N,
  output logic        o_SRAM_WE_N,
  output logic        o_SRAM_OE_N,
  output logic        o_SRAM_LB_N,
  output logic        o_SRAM_UB_N
);

  typedef enum logic [1:0] {IDLE, LO, HI, ACK} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  state_t      state_q, state_nxt;
  logic [3:0]  cnt_q, cnt_nxt;
  logic        gnt_q, gnt_nxt;          // granted port: 1 = port 1
  logic        wren_q, wren_nxt;
  logic [16:0] addr_q, addr_nxt;        // word address, byte addr [18:2]
  logic [31:0] wdata_q, wdata_nxt;
  logic [3:0]  bmask_q, bmask_nxt;
  logic        any_req, pick_p1;

  logic [15:0] rd_lo_q;
  logic [31:0] p0_rdata_q, p1_rdata_q;

  logic        ce_n_q, we_n_q, oe_n_q, lb_n_q, ub_n_q;
  logic        ce_n_nxt, we_n_nxt, oe_n_nxt, lb_n_nxt, ub_n_nxt;
  logic [17:0] sram_addr_q, sram_addr_nxt;
  logic [15:0] dq_out_q, dq_out_nxt;
  logic        dq_oe_q, dq_oe_nxt;
  logic        half_nxt;

  logic        unused_addr_bits;
  assign unused_addr_bits = ^{i_p0_addr[31:19], i_p0_addr[1:0],
                              i_p1_addr[31:19], i_p1_addr[1:0]};

  assign any_req = i_p0_req | i_p1_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_p1_q;  // 1 = port 1 was served last

  // On a tie, grant whichever port was not served last
  always_comb begin
    pick_p1 = i_p1_req & (~i_p0_req | ~last_p1_q);
  end

  // Pointer follows every grant; reset makes port 0 "last", so port 1 wins the first tie
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_p1_q <= 1'b0;
    end else if (state_q == IDLE && any_req) begin
      last_p1_q <= pick_p1;
    end
  end
`else
  // Fixed priority: the LSU port always wins a tie
  always_comb begin
    pick_p1 = i_p1_req;
  end
`endif

  // Next-state, phase counter and request latch
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    gnt_nxt   = gnt_q;
    wren_nxt  = wren_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    bmask_nxt = bmask_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_nxt = pick_p1;
          if (pick_p1) begin
            wren_nxt  = i_p1_wren;
            addr_nxt  = i_p1_addr[18:2];
            wdata_nxt = i_p1_wdata;
            bmask_nxt = i_p1_bmask;
          end else begin
            wren_nxt  = 1'b0;
            addr_nxt  = i_p0_addr[18:2];
            wdata_nxt = 32'h0;
            bmask_nxt = 4'hF;
          end
          cnt_nxt = CNT_INIT;
          if (!wren_nxt || bmask_nxt[1:0] != 2'b00) begin
            state_nxt = LO;
          end else if (bmask_nxt[3:2] != 2'b00) begin
            state_nxt = HI;
          end else begin
            state_nxt = ACK;
          end
        end
      end
      LO: begin
        if (cnt_q == 4'd0) begin
          cnt_nxt   = CNT_INIT;
          state_nxt = (wren_q && bmask_q[3:2] == 2'b00) ? ACK : HI;
        end else begin
          cnt_nxt = cnt_q - 4'd1;
        end
      end
      HI: begin
        if (cnt_q == 4'd0) begin
          state_nxt = ACK;
        end else begin
          cnt_nxt = cnt_q - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // SRAM pin values for the coming cycle, derived from the next state so the pins are registered
  always_comb begin
    ce_n_nxt      = 1'b1;
    we_n_nxt      = 1'b1;
    oe_n_nxt      = 1'b1;
    lb_n_nxt      = 1'b1;
    ub_n_nxt      = 1'b1;
    sram_addr_nxt = sram_addr_q;
    dq_out_nxt    = dq_out_q;
    dq_oe_nxt     = 1'b0;
    half_nxt      = (state_nxt == HI);
    if (state_nxt == LO || state_nxt == HI) begin
      ce_n_nxt      = 1'b0;
      sram_addr_nxt = {addr_nxt, half_nxt};
      if (!wren_nxt) begin
        oe_n_nxt = 1'b0;
        lb_n_nxt = 1'b0;
        ub_n_nxt = 1'b0;
      end else begin
        lb_n_nxt = half_nxt ? ~bmask_nxt[2] : ~bmask_nxt[0];
        ub_n_nxt = half_nxt ? ~bmask_nxt[3] : ~bmask_nxt[1];
        // First cycle of a write phase is address setup with the bus released
        if (cnt_nxt != CNT_INIT) begin
          we_n_nxt   = 1'b0;
          dq_oe_nxt  = 1'b1;
          dq_out_nxt = half_nxt ? wdata_nxt[31:16] : wdata_nxt[15:0];
        end
      end
    end
  end

  // Control state and latched request
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      gnt_q   <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= 17'h0;
      wdata_q <= 32'h0;
      bmask_q <= 4'h0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      gnt_q   <= gnt_nxt;
      wren_q  <= wren_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      bmask_q <= bmask_nxt;
    end
  end

  // Registered SRAM pins; reset drops straight back to idle strobes and a released bus
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      sram_addr_q <= 18'h0;
      dq_out_q    <= 16'h0;
      dq_oe_q     <= 1'b0;
    end else begin
      ce_n_q      <= ce_n_nxt;
      we_n_q      <= we_n_nxt;
      oe_n_q      <= oe_n_nxt;
      lb_n_q      <= lb_n_nxt;
      ub_n_q      <= ub_n_nxt;
      sram_addr_q <= sram_addr_nxt;
      dq_out_q    <= dq_out_nxt;
      dq_oe_q     <= dq_oe_nxt;
    end
  end

  // Read capture on the last cycle of each phase; port rdata only changes on entry to ACK
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_lo_q    <= 16'h0;
      p0_rdata_q <= 32'h0;
      p1_rdata_q <= 32'h0;
    end else if (!wren_q && cnt_q == 4'd0) begin
      if (state_q == LO) begin
        rd_lo_q <= o_SRAM_DQ;
      end else if (state_q == HI) begin
        if (gnt_q) begin
          p1_rdata_q <= {o_SRAM_DQ, rd_lo_q};
        end else begin
          p0_rdata_q <= {o_SRAM_DQ, rd_lo_q};
        end
      end
    end
  end

  assign o_SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign o_SRAM_ADDR = sram_addr_q;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_WE_N = we_n_q;
  assign o_SRAM_OE_N = oe_n_q;
  assign o_SRAM_LB_N = lb_n_q;
  assign o_SRAM_UB_N = ub_n_q;

  assign o_p0_rdata = p0_rdata_q;
  assign o_p1_rdata = p1_rdata_q;
  assign o_p0_ack   = (state_q == ACK) && !gnt_q;
  assign o_p1_ack   = (state_q == ACK) && gnt_q;
  assign o_busy     = (state_q != IDLE);

endmodule
